// File: rtl/pipe_addsub_lanes.sv
// pipe_addsub_lanes: LANES independent WIDTH-bit add/sub units behind an
// elastic STAGES-deep pipeline with valid/ready handshakes at both ends.
// Arithmetic happens once, at entry to stage 0; later stages only carry the
// payload. Each lane reports carry (add) or borrow (sub) and signed overflow,
// and can optionally saturate its unsigned result. STAGES must be 1..8.
module pipe_addsub_lanes #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sub,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_carry,
  output logic [LANES-1:0]       out_ovf
);

  localparam int DW = LANES * WIDTH;

  // One lane: returns {ovf, carry_or_borrow, result}. Overflow is judged on
  // the raw wrapped result, before any saturation.
  function automatic logic [WIDTH+1:0] lane_calc(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sub
  );
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] r;
    logic             cy;
    logic             ov;
    b_op = sub ? ~b : b;
    sum  = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    cy   = sub ? ~sum[WIDTH] : sum[WIDTH];
    if (sub) begin
      ov = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
    if ((SAT != 32'sd0) && cy) begin
      r = sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end else begin
      r = sum[WIDTH-1:0];
    end
    return {ov, cy, r};
  endfunction

  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0][DW-1:0]    data_q, data_d;
  logic [STAGES-1:0][LANES-1:0] carry_q, carry_d;
  logic [STAGES-1:0][LANES-1:0] ovf_q, ovf_d;
  logic [STAGES-1:0]            adv_s;
  logic [DW-1:0]                ent_data_s;
  logic [LANES-1:0]             ent_carry_s;
  logic [LANES-1:0]             ent_ovf_s;

  // Entry arithmetic: each lane has its own adder, no carry between lanes.
  always_comb begin
    logic [WIDTH+1:0] lane_res;
    ent_data_s  = {DW{1'b0}};
    ent_carry_s = {LANES{1'b0}};
    ent_ovf_s   = {LANES{1'b0}};
    lane_res    = {(WIDTH+2){1'b0}};
    for (int k = 0; k < LANES; k++) begin
      lane_res = lane_calc(in_a[k*WIDTH +: WIDTH], in_b[k*WIDTH +: WIDTH], in_sub);
      ent_data_s[k*WIDTH +: WIDTH] = lane_res[WIDTH-1:0];
      ent_carry_s[k]               = lane_res[WIDTH];
      ent_ovf_s[k]                 = lane_res[WIDTH+1];
    end
  end

  // Stage i may advance when the consumer takes the output or any stage from
  // i to the tail is empty (bubbles collapse); written without a chain so the
  // vector never feeds itself.
  always_comb begin
    logic acc;
    adv_s = {STAGES{1'b0}};
    acc   = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      acc = out_ready;
      for (int j = i; j < STAGES; j++) begin
        acc = acc | ~v_q[j];
      end
      adv_s[i] = acc;
    end
  end

  // Ready is held low while reset is asserted, independent of in_valid.
  always_comb begin
    in_ready = rst & adv_s[0];
  end

  // Next state of every stage: load from upstream on advance, otherwise hold.
  always_comb begin
    v_d     = v_q;
    data_d  = data_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (adv_s[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        data_d[0]  = ent_data_s;
        carry_d[0] = ent_carry_s;
        ovf_d[0]   = ent_ovf_s;
      end else begin
        data_d[0]  = data_q[0];
        carry_d[0] = carry_q[0];
        ovf_d[0]   = ovf_q[0];
      end
    end else begin
      v_d[0] = v_q[0];
    end
    for (int i = 1; i < STAGES; i++) begin
      if (adv_s[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          data_d[i]  = data_q[i-1];
          carry_d[i] = carry_q[i-1];
          ovf_d[i]   = ovf_q[i-1];
        end else begin
          data_d[i]  = data_q[i];
          carry_d[i] = carry_q[i];
          ovf_d[i]   = ovf_q[i];
        end
      end else begin
        v_d[i] = v_q[i];
      end
    end
  end

  // Pipeline registers; asynchronous reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q     <= {STAGES{1'b0}};
      data_q  <= {(STAGES*DW){1'b0}};
      carry_q <= {(STAGES*LANES){1'b0}};
      ovf_q   <= {(STAGES*LANES){1'b0}};
    end else begin
      v_q     <= v_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come straight from the last stage registers.
  always_comb begin
    out_valid = v_q[STAGES-1];
    out_data  = data_q[STAGES-1];
    out_carry = carry_q[STAGES-1];
    out_ovf   = ovf_q[STAGES-1];
  end

endmodule

// File: tb/tb_pipe_addsub_lanes.sv
// Bench for pipe_addsub_lanes: three instances (4 lanes x 8 bits):
//   0: STAGES=2 SAT=0, 1: STAGES=2 SAT=1, 2: STAGES=3 SAT=0.
module tb_pipe_addsub_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid [3];
  logic        in_ready [3];
  logic        in_sub   [3];
  logic [31:0] in_a     [3];
  logic [31:0] in_b     [3];
  logic        out_valid[3];
  logic        out_ready[3];
  logic [31:0] out_data [3];
  logic [3:0]  out_carry[3];
  logic [3:0]  out_ovf  [3];

  int checks   = 0;
  int failures = 0;
  int stg_of[3] = '{2, 2, 3};
  int sat_of[3] = '{0, 1, 0};

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
    logic [3:0]  o;
  } res_t;

  typedef struct {
    int          id;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [3:0]  c;
    logic [3:0]  o;
  } vec_t;

  res_t exp_q[$];
  logic hold_v;
  res_t hold_r;

  pipe_addsub_lanes #(.WIDTH(8), .LANES(4), .STAGES(2), .SAT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_sub(in_sub[0]), .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_carry(out_carry[0]),
    .out_ovf(out_ovf[0]));

  pipe_addsub_lanes #(.WIDTH(8), .LANES(4), .STAGES(2), .SAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_sub(in_sub[1]), .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_carry(out_carry[1]),
    .out_ovf(out_ovf[1]));

  pipe_addsub_lanes #(.WIDTH(8), .LANES(4), .STAGES(3), .SAT(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_sub(in_sub[2]), .in_a(in_a[2]), .in_b(in_b[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_carry(out_carry[2]),
    .out_ovf(out_ovf[2]));

  // Reference: plain integer arithmetic per byte lane.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input int sat);
    res_t r;
    int ua, ub, s, sa, sb, ss, rv;
    logic cy, ov;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      ua = int'(a[k*8 +: 8]);
      ub = int'(b[k*8 +: 8]);
      s  = sub ? ua - ub : ua + ub;
      cy = sub ? (s < 0) : (s > 255);
      rv = s & 255;
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      ss = sub ? sa - sb : sa + sb;
      ov = (ss > 127) || (ss < -128);
      if (sat != 0 && cy) rv = sub ? 0 : 255;
      r.d[k*8 +: 8] = rv[7:0];
      r.c[k] = cy;
      r.o[k] = ov;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One clock: evaluate handshakes at negedge, return at posedge+1.
  task automatic cyc(input int id, output logic acc, output logic emit);
    res_t g, e;
    @(negedge clk);
    g = {out_data[id], out_carry[id], out_ovf[id]};
    if (hold_v) begin
      chk("stall_valid", out_valid[id], 1'b1);
      chk("stall_hold", g, hold_r);
    end
    hold_v = out_valid[id] && !out_ready[id];
    hold_r = g;
    acc  = in_valid[id] && in_ready[id];
    emit = out_valid[id] && out_ready[id];
    if (acc) exp_q.push_back(model(in_a[id], in_b[id], in_sub[id], sat_of[id]));
    if (emit) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0h expected none", g);
      end else begin
        e = exp_q.pop_front();
        chk("result", g, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int id, input int n, input int rdy_pct);
    int sent, got, cycles;
    logic acc, em, last_acc;
    exp_q.delete();
    hold_v = 1'b0;
    sent = 0; got = 0; cycles = 0; last_acc = 1'b0;
    in_valid[id] = 1'b0;
    while ((sent < n || exp_q.size() != 0) && cycles < n * 6 + 100) begin
      if (last_acc || !in_valid[id]) begin
        if (sent < n && $urandom_range(0, 99) < 70) begin
          in_valid[id] = 1'b1;
          in_a[id]     = $urandom;
          in_b[id]     = $urandom;
          in_sub[id]   = 1'($urandom_range(0, 1));
        end else begin
          in_valid[id] = 1'b0;
        end
      end
      out_ready[id] = ($urandom_range(0, 99) < rdy_pct);
      cyc(id, acc, em);
      last_acc = acc;
      sent += int'(acc);
      got  += int'(em);
      cycles++;
    end
    in_valid[id]  = 1'b0;
    out_ready[id] = 1'b1;
    chk("rand_count", got, n);
  endtask

  vec_t vt[14];
  logic [31:0] bpa[5];
  logic [31:0] bpb[5];
  logic        bps[5];

  initial begin
    int id, lat, nxt, emits;
    logic acc, em;

    vt[0]  = '{0, 1'b0, 32'h000000C8, 32'h00000064, 32'h0000002C, 4'b0001, 4'b0000};
    vt[1]  = '{1, 1'b0, 32'h000000C8, 32'h00000064, 32'h000000FF, 4'b0001, 4'b0000};
    vt[2]  = '{0, 1'b1, 32'h00000005, 32'h00000007, 32'h000000FE, 4'b0001, 4'b0000};
    vt[3]  = '{0, 1'b1, 32'h00000080, 32'h00000001, 32'h0000007F, 4'b0000, 4'b0001};
    vt[4]  = '{0, 1'b0, 32'h7F01FF10, 32'h010101F0, 32'h80020000, 4'b0011, 4'b1000};
    vt[5]  = '{1, 1'b1, 32'h00000005, 32'h00000007, 32'h00000000, 4'b0001, 4'b0000};
    vt[6]  = '{1, 1'b1, 32'h00000080, 32'h00000001, 32'h0000007F, 4'b0000, 4'b0001};
    vt[7]  = '{1, 1'b0, 32'h7F01FF10, 32'h010101F0, 32'h8002FFFF, 4'b0011, 4'b1000};
    vt[8]  = '{0, 1'b1, 32'h00000000, 32'h00000080, 32'h00000080, 4'b0001, 4'b0001};
    vt[9]  = '{2, 1'b0, 32'hFFFFFFFF, 32'h01010101, 32'h00000000, 4'b1111, 4'b0000};
    vt[10] = '{1, 1'b1, 32'h00000000, 32'h00000080, 32'h00000000, 4'b0001, 4'b0001};
    vt[11] = '{0, 1'b0, 32'h00000080, 32'h00000080, 32'h00000000, 4'b0001, 4'b0001};
    vt[12] = '{2, 1'b1, 32'h10203040, 32'h10203041, 32'h000000FF, 4'b0001, 4'b0000};
    vt[13] = '{2, 1'b0, 32'h7F7F7F7F, 32'h01000100, 32'h807F807F, 4'b0000, 4'b1010};

    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_sub[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
      out_ready[i] = 1'b1;
    end
    hold_v = 1'b0;

    // Reset state
    rst = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset_out_valid", out_valid[i], 1'b0);
      chk("reset_in_ready", in_ready[i], 1'b0);
      chk("reset_out_data", {out_data[i], out_carry[i], out_ovf[i]}, 40'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("release_in_ready", in_ready[i], 1'b1);

    // Directed vectors with latency check
    for (int i = 0; i < 14; i++) begin
      id = vt[i].id;
      out_ready[id] = 1'b1;
      in_valid[id]  = 1'b1;
      in_sub[id]    = vt[i].sub;
      in_a[id]      = vt[i].a;
      in_b[id]      = vt[i].b;
      #1;
      chk("vec_in_ready", in_ready[id], 1'b1);
      @(posedge clk);
      #1;
      in_valid[id] = 1'b0;
      lat = 0;
      while (!out_valid[id] && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("vec_latency", lat, stg_of[id] - 1);
      chk("vec_data", out_data[id], vt[i].d);
      chk("vec_carry", out_carry[id], vt[i].c);
      chk("vec_ovf", out_ovf[id], vt[i].o);
      @(posedge clk);
      #1;
      chk("vec_drained", out_valid[id], 1'b0);
    end

    // Backpressure on the 3-stage instance: 5 offered, 3 fit
    for (int i = 0; i < 5; i++) begin
      bpa[i] = $urandom; bpb[i] = $urandom; bps[i] = 1'($urandom_range(0, 1));
    end
    exp_q.delete();
    hold_v = 1'b0;
    out_ready[2] = 1'b0;
    nxt = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid[2] = 1'b1;
      in_a[2] = bpa[nxt]; in_b[2] = bpb[nxt]; in_sub[2] = bps[nxt];
      cyc(2, acc, em);
      nxt += int'(acc);
    end
    chk("bp_accepted", nxt, 3);
    chk("bp_in_ready_full", in_ready[2], 1'b0);
    chk("bp_out_valid", out_valid[2], 1'b1);
    out_ready[2] = 1'b1;
    #1;
    chk("bp_passthru_ready", in_ready[2], 1'b1);
    emits = 0;
    for (int c = 0; c < 30 && (nxt < 5 || exp_q.size() != 0); c++) begin
      if (nxt < 5) begin
        in_valid[2] = 1'b1;
        in_a[2] = bpa[nxt]; in_b[2] = bpb[nxt]; in_sub[2] = bps[nxt];
      end else begin
        in_valid[2] = 1'b0;
      end
      cyc(2, acc, em);
      nxt   += int'(acc);
      emits += int'(em);
    end
    in_valid[2] = 1'b0;
    chk("bp_all_accepted", nxt, 5);
    chk("bp_emitted", emits, 5);

    // Random traffic against the model
    run_random(0, 2000, 80);
    run_random(1, 2000, 50);
    run_random(2, 10000, 60);

    // Asynchronous reset with two transactions in flight
    exp_q.delete();
    hold_v = 1'b0;
    out_ready[0] = 1'b0;
    nxt = 0;
    for (int c = 0; c < 2; c++) begin
      in_valid[0] = 1'b1; in_a[0] = $urandom; in_b[0] = $urandom; in_sub[0] = 1'b0;
      cyc(0, acc, em);
      nxt += int'(acc);
    end
    in_valid[0] = 1'b0;
    chk("rst_inflight", nxt, 2);
    chk("rst_pre_valid", out_valid[0], 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", out_valid[0], 1'b0);
    chk("rst_async_ready", in_ready[0], 1'b0);
    chk("rst_async_data", {out_data[0], out_carry[0], out_ovf[0]}, 40'h0);
    exp_q.delete();
    hold_v = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready", in_ready[0], 1'b1);
    for (int c = 0; c < 4; c++) begin
      chk("rst_no_stale", out_valid[0], 1'b0);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_addsub_lanes.md
Name: pipe_addsub_lanes

Overview:
- Parametrised, elastic successor to the fixed two-stage 8-bit pipelined adder.
- Performs LANES independent WIDTH-bit additions or subtractions per transaction, selected per transaction.
- Result passes through STAGES register stages, with valid/ready backpressure at both ends.
- Reports per-lane carry/borrow and signed overflow; optional unsigned saturation. Sits between operand sources and the arithmetic checker/consumer in the datapath.

Parameters:
- WIDTH, 8: bits per lane operand/result.
- LANES, 1: number of independent lanes packed in each bus.
- STAGES, 2: pipeline depth = unstalled latency in cycles; legal range 1..8.
- SAT, 0: 1 = clamp each lane's unsigned result on carry/borrow; 0 = wrap.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block can accept a transaction this cycle.
- in_sub  input  1  0 = a+b, 1 = a-b, applied to all lanes.
- in_a  input  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH].
- in_b  input  LANES*WIDTH  same packing as in_a.
- out_valid  output  1  result transaction valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  LANES*WIDTH  per-lane result.
- out_carry  output  LANES  add: carry-out; sub: borrow (a<b unsigned).
- out_ovf  output  LANES  signed two's-complement overflow per lane.

Behaviour:
- Reset: clk and rst only; reset is asynchronous and active-low. While rst=0, all stage valid bits clear; out_valid=0, out_data=0, out_carry=0, out_ovf=0, in_ready=0. Payload registers also clear to 0.
- First cycle after rst deasserts: in_ready=1.
- Handshakes: transfer on in_valid&&in_ready and on out_valid&&out_ready. in_ready does not depend combinationally on in_valid. out_* holds stable while out_valid=1 and out_ready=0.
- Pipeline: stages 0..STAGES-1, each holding valid v[i] plus payload; the last stage drives out_*.
  - adv[STAGES-1] = out_ready || !v[STAGES-1].
  - adv[i] = !v[i] || adv[i+1].
  - in_ready = adv[0].
  - Bubbles collapse: an empty stage always accepts from upstream.
- Arithmetic is computed combinationally at entry to stage 0 and then carried unchanged through later stages.
  - Per lane, sum = {0,a} + {0,b} for add, or {0,a} + {0,~b} + 1 for sub, in WIDTH+1 bits.
  - Add: carry = sum[WIDTH]. Sub: borrow = !sum[WIDTH].
  - ovf: add = (a[msb]==b[msb]) && (r[msb]!=a[msb]); sub = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - SAT=1: on carry (add) r = all-ones; on borrow (sub) r = 0. out_carry/out_ovf still report the raw condition; ovf is computed on the unsaturated result.
  - Lanes never interact; no carry crosses a lane boundary.
- Latency: a transaction accepted at edge N with no stalls presents on out_* after edge N+STAGES-1, i.e. STAGES cycles including the acceptance cycle. With STAGES=2 this matches the legacy 2-cycle timing.
- Throughput: one transaction per cycle while out_ready=1. Sustained stall: accepts up to STAGES transactions, then in_ready=0. Simultaneous accept and emit while full: in_ready=1 (pass-through), no loss or duplication.
- Ordering: strict FIFO; transactions never reorder or drop.
- Reset mid-operation: all in-flight transactions are discarded immediately (asynchronous); nothing is emitted afterwards.

Test Plan:
- STAGES=2, LANES=1, out_ready=1; a=8'd200, b=8'd100, add -> out_data=8'd44, carry=1, ovf=0, out_valid exactly 2 cycles after accept. With SAT=1 -> out_data=8'hFF, carry=1.
- Sub a=8'd5, b=8'd7 -> out_data=8'hFE, carry(borrow)=1, ovf=0. Sub a=8'h80, b=8'h01 -> out_data=8'h7F, ovf=1, borrow=0.
- LANES=4, in_a=32'h7F_01_FF_10, in_b=32'h01_01_01_F0, add -> out_data=32'h80_02_00_00, carry=4'b0011, ovf=4'b1000 (lane 3 = top byte); confirms no cross-lane carry.
- Backpressure, STAGES=3: out_ready=0, 5 back-to-back valid inputs -> exactly 3 accepted, in_ready=0 afterwards. Release out_ready -> results emitted in order, then remaining inputs accepted, none lost.
- Random valid/ready stimulus, 10k transactions -> every output equals a reference model of a±b with lane flags, in order. The bench asserts equality, as the legacy property does.
- Assert rst=0 asynchronously mid-stream with 2 transactions in flight -> out_valid drops the same cycle without a clock edge, no stale results afterwards, in_ready=1 one cycle after release.
